// File: rtl/out_channel_streamer.sv
// out_channel_streamer: captures program `out` words into a circular buffer and
// streams them to a host as little-endian bytes over a valid/ready handshake.
module out_channel_streamer #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          outWrite,
  input  logic [MemoryElementWidth-1:0] outData,
  input  logic                          finished,
  output logic                          outFull,
  output logic [7:0]                    count,
  output logic                          overflow,
  output logic                          txValid,
  output logic [7:0]                    txData,
  input  logic                          txReady,
  output logic                          drained
);

  localparam int              PW      = (NOut > 1) ? $clog2(NOut) : 1;
  localparam logic [7:0]      LP_NOUT = 8'(NOut);
  localparam logic [PW-1:0]   LP_LAST = PW'(NOut - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [MemoryElementWidth-1:0] r_mem [NOut];
  logic [PW-1:0]                 r_wp;
  logic [PW-1:0]                 r_rp;
  logic [7:0]                    r_count;
  logic [7:0]                    w_count_next;
  logic                          r_overflow;
  logic                          r_drained;
  logic [MemoryElementWidth-1:0] r_shift;
  logic                          w_pop;
  logic                          w_accept;
  logic                          w_drop;

  // Pop/accept decisions; a pop frees a slot so a write at full still lands.
  always_comb begin
    w_pop    = (r_state == S_IDLE) && (r_count != 8'd0);
    w_accept = outWrite && ((r_count != LP_NOUT) || w_pop);
    w_drop   = outWrite && !w_accept;
  end

  // Serializer next state: IDLE pops, LO/HI advance only on a handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop)   w_state_next = S_LO;
      S_LO:    if (txReady) w_state_next = S_HI;
      S_HI:    if (txReady) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Occupancy update; simultaneous write and pop leaves count unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_accept, w_pop})
      2'b10:   w_count_next = r_count + 8'd1;
      2'b01:   w_count_next = r_count - 8'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Buffer storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (w_accept) r_mem[r_wp] <= outData;
  end

  // Control state: pointers, count, serializer, sticky overflow, drained flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drained  <= 1'b0;
      r_shift    <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_accept) r_wp <= (r_wp == LP_LAST) ? '0 : r_wp + 1'b1;
      if (w_pop) begin
        r_shift <= r_mem[r_rp];
        r_rp    <= (r_rp == LP_LAST) ? '0 : r_rp + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
      // Evaluated on next-state values so drained tracks the state after this edge.
      r_drained <= finished && (w_count_next == 8'd0) && (w_state_next == S_IDLE);
    end
  end

  // Output decode; host-facing flags are forced low while reset is asserted.
  always_comb begin
    count    = r_count;
    overflow = r_overflow;
    outFull  = !reset && (r_count == LP_NOUT);
    drained  = !reset && r_drained;
    txValid  = !reset && (r_state != S_IDLE);
    txData   = '0;
    if (!reset) begin
      case (r_state)
        S_LO:    txData = r_shift[7:0];
        S_HI:    txData = 8'(r_shift[MemoryElementWidth-1:8]);
        default: txData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_out_channel_streamer.sv
// Directed self-checking bench for out_channel_streamer (default 12-bit, depth 6).
module tb_out_channel_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        outWrite;
  logic [11:0] outData;
  logic        finished;
  logic        outFull;
  logic [7:0]  count;
  logic        overflow;
  logic        txValid;
  logic [7:0]  txData;
  logic        txReady;
  logic        drained;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  logic [7:0] basic_bytes [12] = '{8'h03, 8'h00, 8'h21, 8'h00, 8'h02, 8'h00,
                                   8'h16, 8'h00, 8'h01, 8'h00, 8'h0B, 8'h00};
  logic [11:0] basic_words [6] = '{12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11};

  out_channel_streamer #(.MemoryElementWidth(12), .NOut(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .outWrite (outWrite),
    .outData  (outData),
    .finished (finished),
    .outFull  (outFull),
    .count    (count),
    .overflow (overflow),
    .txValid  (txValid),
    .txData   (txData),
    .txReady  (txReady),
    .drained  (drained)
  );

  always #5 clock = ~clock;

  // Record every byte that will be handshaken at the next rising edge.
  always @(negedge clock) begin
    if (txValid && txReady) rx_q.push_back(txData);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [11:0] d);
    outWrite = 1'b1;
    outData  = d;
    tick();
    outWrite = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s[%0d]", tag, i),
               (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD, {24'd0, exp_q[i]});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    outWrite = 1'b0;
    outData  = '0;
    finished = 1'b0;
    txReady  = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_txValid", txValid, 0);
    check_eq("rst_txData", txData, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_outFull", outFull, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_drained", drained, 0);
    reset = 1'b0;
    tick();

    // Basic stream, no backpressure
    txReady = 1'b1;
    rx_q.delete();
    exp_q.delete();
    foreach (basic_bytes[i]) exp_q.push_back(basic_bytes[i]);
    foreach (basic_words[i]) do_write(basic_words[i]);
    finished = 1'b1;
    wait_bytes(12, 60);
    tick();
    compare_stream("basic");
    check_eq("basic_overflow", overflow, 0);
    check_eq("basic_drained", drained, 1);

    // Backpressure, with drained falling after an accepted write
    txReady = 1'b0;
    do_write(12'hABC);
    check_eq("bp_count", count, 1);
    check_eq("bp_drained_fall", drained, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_valid%0d", i), txValid, 1);
      check_eq($sformatf("bp_lo%0d", i), txData, 8'hBC);
      tick();
    end
    txReady = 1'b1;
    check_eq("bp_lo_final", txData, 8'hBC);
    tick();
    check_eq("bp_hi_valid", txValid, 1);
    check_eq("bp_hi", txData, 8'h0A);
    tick();
    check_eq("bp_idle_valid", txValid, 0);
    check_eq("bp_drained", drained, 1);
    finished = 1'b0;

    // Overflow
    txReady = 1'b0;
    for (int w = 1; w <= 7; w++) do_write(12'(w));
    check_eq("ovf_count", count, 6);
    check_eq("ovf_full", outFull, 1);
    check_eq("ovf_pre", overflow, 0);
    do_write(12'd8);
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_count_hold", count, 6);
    rx_q.delete();
    exp_q.delete();
    for (int w = 1; w <= 7; w++) begin
      exp_q.push_back(8'(w));
      exp_q.push_back(8'h00);
    end
    txReady = 1'b1;
    wait_bytes(14, 80);
    repeat (8) tick();
    compare_stream("ovf");
    check_eq("ovf_sticky", overflow, 1);

    // Reset clears overflow
    do_reset();
    check_eq("ovf_rst_clear", overflow, 0);

    // Simultaneous write and pop at full, with pointer wrap
    txReady = 1'b0;
    rx_q.delete();
    exp_q.delete();
    for (int w = 16'h10; w <= 16'h17; w++) begin
      exp_q.push_back(8'(w));
      exp_q.push_back(8'h00);
    end
    for (int w = 16'h10; w <= 16'h16; w++) do_write(12'(w));
    txReady = 1'b1;
    tick();
    tick();
    txReady = 1'b0;
    check_eq("sim_idle_valid", txValid, 0);
    check_eq("sim_pre_count", count, 6);
    do_write(12'h017);
    check_eq("sim_count", count, 6);
    check_eq("sim_overflow", overflow, 0);
    check_eq("sim_valid", txValid, 1);
    txReady = 1'b1;
    wait_bytes(16, 80);
    repeat (6) tick();
    compare_stream("wrap");
    check_eq("wrap_count", count, 0);

    // Width extremes
    rx_q.delete();
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    do_write(12'hFFF);
    do_write(12'h000);
    wait_bytes(4, 30);
    repeat (4) tick();
    compare_stream("extreme");

    // Reset mid-transfer
    txReady = 1'b0;
    for (int w = 1; w <= 4; w++) do_write(12'(w));
    txReady = 1'b1;
    tick();
    txReady = 1'b0;
    check_eq("mid_hi_valid", txValid, 1);
    check_eq("mid_hi_data", txData, 8'h00);
    check_eq("mid_count", count, 3);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_valid", txValid, 0);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_overflow", overflow, 0);
    check_eq("mid_rst_drained", drained, 0);
    reset = 1'b0;
    tick();
    check_eq("mid_post_valid", txValid, 0);
    rx_q.delete();
    exp_q.delete();
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h00);
    txReady = 1'b1;
    do_write(12'd5);
    wait_bytes(2, 20);
    repeat (6) tick();
    compare_stream("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
